// File: rtl/multi_counter.sv
// multi_counter: bank of CHANNELS independent WIDTH-bit up/down counters
//   Clk      clock, rising edge
//   Reset    asynchronous active-low reset
//   Slt      channel select (values >= CHANNELS select nothing)
//   En       step selected channel; Dir 0=up 1=down; Sat 0=wrap 1=saturate
//   Load     load LoadVal into selected channel (beats En)
//   Clr      clear all counts and flags (beats Load and En)
//   Count    channel i at [i*WIDTH +: WIDTH]
//   Ovf      sticky per-channel limit flag
//   Wrap     one-cycle pulse after a step that hit a limit
module multi_counter #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [SEL_W-1:0]          Slt,
  input  logic                      En,
  input  logic                      Dir,
  input  logic                      Sat,
  input  logic                      Load,
  input  logic [WIDTH-1:0]          LoadVal,
  input  logic                      Clr,
  output logic [CHANNELS*WIDTH-1:0] Count,
  output logic [CHANNELS-1:0]       Ovf,
  output logic                      Wrap
);
  logic [CHANNELS*WIDTH-1:0] count_q, count_d;
  logic [CHANNELS-1:0]       ovf_q, ovf_d;
  logic                      wrap_q, wrap_d;
  logic [WIDTH-1:0]          c;
  logic                      lim;
  // Out-of-range selects match no channel, so Load/En fall through as no-ops.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    wrap_d  = 1'b0;
    c       = '0;
    lim     = 1'b0;
    if (Clr) begin
      count_d = '0;
      ovf_d   = '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(Slt) == i) begin
          c   = count_q[i*WIDTH +: WIDTH];
          lim = Dir ? (c == '0) : (c == '1);
          if (Load) begin
            count_d[i*WIDTH +: WIDTH] = LoadVal;
            ovf_d[i] = 1'b0;
          end else if (En) begin
            // Modular +/-1 already produces the wrapped value; saturation just holds.
            count_d[i*WIDTH +: WIDTH] = (lim && Sat) ? c : (Dir ? c - 1'b1 : c + 1'b1);
            ovf_d[i] = ovf_q[i] | lim;
            wrap_d   = lim;
          end
        end
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      ovf_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wrap_q  <= wrap_d;
    end
  end
  assign Count = count_q;
  assign Ovf   = ovf_q;
  assign Wrap  = wrap_q;
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed table, corner sequences and randomized model check
module tb_multi_counter;
  localparam int W = 4, N = 3, S = 2;
  logic           Clk, Reset, En, Dir, Sat, Load, Clr, Wrap;
  logic [S-1:0]   Slt;
  logic [W-1:0]   LoadVal;
  logic [N*W-1:0] Count;
  logic [N-1:0]   Ovf;
  int checks = 0, errors = 0;
  int m_cnt[N];
  bit m_ovf[N];
  bit m_wrap;

  multi_counter #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
    .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Dir(Dir), .Sat(Sat),
    .Load(Load), .LoadVal(LoadVal), .Clr(Clr), .Count(Count), .Ovf(Ovf), .Wrap(Wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit clr, load, en, dir, sat;
    logic [S-1:0] slt;
    logic [W-1:0] lv;
    logic [N*W-1:0] exp_count;
    logic [N-1:0] exp_ovf;
    bit exp_wrap;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit clr, load, en, dir, sat, input logic [S-1:0] slt, input logic [W-1:0] lv);
    Clr = clr; Load = load; En = en; Dir = dir; Sat = sat; Slt = slt; LoadVal = lv;
  endtask

  // Reference model written straight from the operation rules.
  task automatic model_step(input bit clr, load, en, dir, sat, input int slt, input int lv);
    int mx;
    mx = (1 << W) - 1;
    m_wrap = 0;
    if (clr) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    end else if (slt < N) begin
      if (load) begin
        m_cnt[slt] = lv; m_ovf[slt] = 0;
      end else if (en) begin
        if (!dir) begin
          if (m_cnt[slt] == mx) begin m_ovf[slt] = 1; m_wrap = 1; m_cnt[slt] = sat ? mx : 0; end
          else m_cnt[slt] = m_cnt[slt] + 1;
        end else begin
          if (m_cnt[slt] == 0) begin m_ovf[slt] = 1; m_wrap = 1; m_cnt[slt] = sat ? 0 : mx; end
          else m_cnt[slt] = m_cnt[slt] - 1;
        end
      end
    end
  endtask

  function automatic logic [N*W-1:0] model_count();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_cnt[i]);
    return r;
  endfunction

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_ovf[i];
    return r;
  endfunction

  initial begin
    bit clr, load, en, dir, sat;
    int slt, lv;
    // 1. reset held with En active, then five up-steps on channel 0
    Reset = 1'b0;
    drive(0, 0, 1, 0, 0, 2'd0, 4'd0);
    repeat (3) cyc();
    check("reset_count", 32'(Count), 0);
    check("reset_ovf", 32'(Ovf), 0);
    check("reset_wrap", 32'(Wrap), 0);
    Reset = 1'b1;
    repeat (5) cyc();
    En = 1'b0;
    cyc();
    check("count5", 32'(Count), 32'h005);
    // 2-5. table: {clr,load,en,dir,sat,slt,lv, count,ovf,wrap}
    tbl.push_back('{0,1,0,0,0,2'd1,4'd14, 12'h0E5,3'b000,0});
    tbl.push_back('{0,0,1,0,0,2'd1,4'd0,  12'h0F5,3'b000,0});
    tbl.push_back('{0,0,1,0,0,2'd1,4'd0,  12'h005,3'b010,1});
    tbl.push_back('{0,0,1,0,0,2'd1,4'd0,  12'h015,3'b010,0});
    tbl.push_back('{0,1,0,0,0,2'd2,4'd1,  12'h115,3'b010,0});
    tbl.push_back('{0,0,1,1,1,2'd2,4'd0,  12'h015,3'b010,0});
    tbl.push_back('{0,0,1,1,1,2'd2,4'd0,  12'h015,3'b110,1});
    tbl.push_back('{0,0,1,1,1,2'd2,4'd0,  12'h015,3'b110,1});
    tbl.push_back('{0,1,0,0,0,2'd0,4'd0,  12'h010,3'b110,0});
    tbl.push_back('{0,0,1,1,0,2'd0,4'd0,  12'h01F,3'b111,1});
    tbl.push_back('{0,1,1,0,0,2'd0,4'd9,  12'h019,3'b110,0});
    tbl.push_back('{0,0,1,1,1,2'd2,4'd0,  12'h019,3'b110,1});
    tbl.push_back('{0,1,1,1,0,2'd3,4'd7,  12'h019,3'b110,0});
    tbl.push_back('{0,0,1,0,0,2'd3,4'd0,  12'h019,3'b110,0});
    tbl.push_back('{1,1,1,0,0,2'd1,4'd5,  12'h000,3'b000,0});
    foreach (tbl[k]) begin
      drive(tbl[k].clr, tbl[k].load, tbl[k].en, tbl[k].dir, tbl[k].sat, tbl[k].slt, tbl[k].lv);
      cyc();
      check($sformatf("tbl%0d_count", k), 32'(Count), 32'(tbl[k].exp_count));
      check($sformatf("tbl%0d_ovf", k), 32'(Ovf), 32'(tbl[k].exp_ovf));
      check($sformatf("tbl%0d_wrap", k), 32'(Wrap), 32'(tbl[k].exp_wrap));
    end
    // 6. asynchronous reset between edges mid-count
    drive(0, 0, 1, 0, 0, 2'd0, 4'd0);
    repeat (3) cyc();
    check("pre_async", 32'(Count), 32'h003);
    #2 Reset = 1'b0;
    #1;
    check("async_count", 32'(Count), 0);
    check("async_ovf", 32'(Ovf), 0);
    cyc();
    check("held_count", 32'(Count), 0);
    #2 Reset = 1'b1;
    cyc();
    check("resume_count", 32'(Count), 32'h001);
    // Randomized run against the model, starting from a clear.
    drive(1, 0, 0, 0, 0, 2'd0, 4'd0);
    cyc();
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int it = 0; it < 400; it++) begin
      clr  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = $urandom_range(0, 1);
      sat  = $urandom_range(0, 1);
      slt  = $urandom_range(0, 3);
      lv   = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 15 : 0) : $urandom_range(0, 15);
      drive(clr, load, en, dir, sat, S'(slt), W'(lv));
      model_step(clr, load, en, dir, sat, slt, lv);
      cyc();
      check("rnd_count", 32'(Count), 32'(model_count()));
      check("rnd_ovf", 32'(Ovf), 32'(model_ovf()));
      check("rnd_wrap", 32'(Wrap), 32'(m_wrap));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
